// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic LEGv8 instruction requests into 32-bit machine
// words, buffers them in a small FIFO and streams them to instruction memory at
// auto-incrementing byte addresses.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. The producer holds its payload stable while
// valid && !ready. Ready never depends on valid in the same cycle.
//  - request side : in_valid / in_ready. in_ready = !full. A pop in the same
//                   cycle does not free a slot early.
//  - memory side  : wr_valid / wr_ready. wr_valid = !empty. wr_addr and
//                   wr_data hold while stalled.
// The block has no FSM. Its observable state is the FIFO occupancy, the write
// address, the sticky error flag and the word counter, all of which are outputs
// or directly derived from outputs.
module instr_encoder #(
   parameter int unsigned                DEPTH    = 4,
   parameter int unsigned                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]          BASE_RST = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        op_sel,
   input  logic [4:0]        rd,
   input  logic [4:0]        rn,
   input  logic [4:0]        rm,
   input  logic [5:0]        shamt,
   input  logic [25:0]       imm,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              err,
   input  logic              err_clr,
   output logic [15:0]       word_count
);

   localparam int unsigned     PW       = $clog2(DEPTH);
   localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [31:0]       mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW:0]       cnt_q, cnt_d;
   logic              ready_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wcnt_q;
   logic [31:0]       enc_d;
   logic              full, empty, accept, legal, push, pop;

   assign full     = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == '0);
   assign in_ready = ready_q && !full;
   assign accept   = in_valid && in_ready;
   assign legal    = (op_sel < 5'd20);
   assign push     = accept && legal;
   assign pop      = wr_valid && wr_ready;

   assign wr_valid   = !empty;
   assign wr_data    = empty ? 32'h0 : mem_q[rptr_q];
   assign wr_addr    = addr_q;
   assign err        = err_q;
   assign word_count = wcnt_q;

   // Combinational encoder: pick the format and opcode from op_sel.
   always_comb begin
      enc_d = '0;
      case (op_sel)
         5'd0:  enc_d = {11'b10001011000, rm, shamt, rn, rd};          // ADD
         5'd1:  enc_d = {11'b11001011000, rm, shamt, rn, rd};          // SUB
         5'd2:  enc_d = {11'b10001010000, rm, shamt, rn, rd};          // AND
         5'd3:  enc_d = {11'b10101010000, rm, shamt, rn, rd};          // ORR
         5'd4:  enc_d = {10'b1001000100, imm[11:0], rn, rd};           // ADDI
         5'd5:  enc_d = {10'b1101000100, imm[11:0], rn, rd};           // SUBI
         5'd6:  enc_d = {10'b1001001000, imm[11:0], rn, rd};           // ANDI
         5'd7:  enc_d = {10'b1011001000, imm[11:0], rn, rd};           // ORRI
         5'd8:  enc_d = {10'b1101001000, imm[11:0], rn, rd};           // EORI
         5'd9:  enc_d = {11'b11111000010, imm[8:0], 2'b00, rn, rd};    // LDUR
         5'd10: enc_d = {11'b00111000010, imm[8:0], 2'b00, rn, rd};    // LDURB
         5'd11: enc_d = {11'b01111000010, imm[8:0], 2'b00, rn, rd};    // LDURH
         5'd12: enc_d = {11'b10111000100, imm[8:0], 2'b00, rn, rd};    // LDURSW
         5'd13: enc_d = {11'b11111000000, imm[8:0], 2'b00, rn, rd};    // STUR
         5'd14: enc_d = {11'b00111000000, imm[8:0], 2'b00, rn, rd};    // STURB
         5'd15: enc_d = {11'b01111000000, imm[8:0], 2'b00, rn, rd};    // STURH
         5'd16: enc_d = {11'b10111000000, imm[8:0], 2'b00, rn, rd};    // STURW
         5'd17: enc_d = {8'b10110100, imm[18:0], rd};                  // CBZ
         5'd18: enc_d = {8'b10110101, imm[18:0], rd};                  // CBNZ
         5'd19: enc_d = {6'b000101, imm[25:0]};                        // B
         default: enc_d = '0;
      endcase
   end

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= enc_d;
   end

   // FIFO pointers, occupancy and the post-reset ready enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         cnt_q   <= cnt_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Write address: a base load wins over the post-write increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         addr_q <= BASE_RST;
      else if (base_load) addr_q <= base_addr & ALIGN_MASK;
      else if (pop)       addr_q <= addr_q + ADDR_W'(4);
   end

   // Sticky error: an illegal accept beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                err_q <= 1'b0;
      else if (accept && !legal) err_q <= 1'b1;
      else if (err_clr)          err_q <= 1'b0;
   end

   // Saturating count of words handed to instruction memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          wcnt_q <= '0;
      else if (pop && wcnt_q != 16'hFFFF)  wcnt_q <= wcnt_q + 16'd1;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed requests with hand-encoded expected words,
// a scoreboard queue of {address, word} and a monitor that pops on every
// memory write. Inputs change 1 time unit after a rising edge; outputs are
// sampled on the falling edge.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op_sel = '0, rd = '0, rn = '0, rm = '0;
   logic [5:0]  shamt = '0;
   logic [25:0] imm = '0;
   logic        base_load = 1'b0;
   logic [31:0] base_addr = '0;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        err;
   logic        err_clr = 1'b0;
   logic [15:0] word_count;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];

   instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_RST(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .imm(imm),
      .base_load(base_load), .base_addr(base_addr), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .err(err),
      .err_clr(err_clr), .word_count(word_count)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: present one request, hold until accepted (bounded)
   task automatic send(input logic [4:0] op, input logic [4:0] rd_v, input logic [4:0] rn_v,
                       input logic [4:0] rm_v, input logic [5:0] sh_v, input logic [25:0] im_v,
                       input logic do_push, input logic [31:0] exp_d, input logic [31:0] exp_a);
      int t;
      if (do_push) exp_q.push_back({exp_a, exp_d});
      op_sel = op; rd = rd_v; rn = rn_v; rm = rm_v; shamt = sh_v; imm = im_v;
      in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 50) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 for op %0d", op);
            in_valid = 1'b0;
            return;
         end
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 || wr_valid) begin
         @(negedge clk);
         t++;
         if (t > 60) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            break;
         end
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_write: got %h @%h want no write", wr_data, wr_addr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e[63:32]);
            chk("wr_data", wr_data, e[31:0]);
         end
      end
   end

   // stimulus
   initial begin
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      step();
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_reset", 32'(in_ready), 32'd1);

      // single ADD, one-cycle latency
      step();
      wr_ready = 1'b1;
      send(5'd0, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0, 1'b1, 32'h8B030041, 32'h0);
      @(negedge clk);
      chk("add_latency_valid", 32'(wr_valid), 32'd1);
      wait_drain();
      chk("count_after_add", 32'(word_count), 32'd1);

      // back-to-back I, D, CB, B formats
      step();
      send(5'd4,  5'd9,  5'd9, 5'd0, 6'd0, 26'd1,       1'b1, 32'h91000529, 32'd4);
      send(5'd9,  5'd10, 5'd1, 5'd0, 6'd0, 26'd8,       1'b1, 32'hF840802A, 32'd8);
      send(5'd17, 5'd5,  5'd0, 5'd0, 6'd0, 26'h7FFFF,   1'b1, 32'hB4FFFFE5, 32'd12);
      send(5'd19, 5'd0,  5'd0, 5'd0, 6'd0, 26'd3,       1'b1, 32'h14000003, 32'd16);
      send(5'd18, 5'd0,  5'd0, 5'd0, 6'd0, 26'd0,       1'b1, 32'hB5000000, 32'd20);
      wait_drain();
      chk("count_after_burst", 32'(word_count), 32'd6);

      // fill the FIFO with the memory stalled; immediates truncated
      step();
      wr_ready = 1'b0;
      send(5'd1,  5'd3,  5'd4,  5'd5,  6'd0,  26'd0,       1'b1, 32'hCB050083, 32'd24);
      send(5'd3,  5'd31, 5'd31, 5'd31, 6'd63, 26'd0,       1'b1, 32'hAA1FFFFF, 32'd28);
      send(5'd13, 5'd7,  5'd6,  5'd0,  6'd0,  26'h3FFFFFF, 1'b1, 32'hF81FF0C7, 32'd32);
      send(5'd8,  5'd2,  5'd1,  5'd0,  6'd0,  26'h3FFFFFF, 1'b1, 32'hD23FFC22, 32'd36);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_wr_valid", 32'(wr_valid), 32'd1);
      // fifth request stalls
      step();
      exp_q.push_back({32'd40, 32'h922AF000});
      op_sel = 5'd6; rd = 5'd0; rn = 5'd0; rm = 5'd0; shamt = 6'd0; imm = 26'hABC;
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_wr_addr", wr_addr, 32'd24);
      chk("stall_wr_data", wr_data, 32'hCB050083);
      step();
      wr_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_pop", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      wait_drain();
      chk("count_after_fill", 32'(word_count), 32'd11);

      // illegal op: sticky err, nothing written
      step();
      send(5'd25, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_no_write", 32'(wr_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      step();
      err_clr = 1'b1;
      send(5'd20, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 1'b0, 32'h0, 32'h0);
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_set_wins", 32'(err), 32'd1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(err), 32'd0);
      chk("addr_after_illegal", wr_addr, 32'd44);
      step();
      send(5'd7, 5'd4, 5'd5, 5'd0, 6'd0, 26'd1, 1'b1, 32'hB20004A4, 32'd44);
      wait_drain();
      chk("count_after_orri", 32'(word_count), 32'd12);

      // base load with ignored low bits, then address wrap
      step();
      base_load = 1'b1;
      base_addr = 32'hFFFFFFFF;
      step();
      base_load = 1'b0;
      @(negedge clk);
      chk("base_loaded", wr_addr, 32'hFFFFFFFC);
      step();
      send(5'd11, 5'd1, 5'd2, 5'd0, 6'd0, 26'd4,     1'b1, 32'h78404041, 32'hFFFFFFFC);
      send(5'd16, 5'd3, 5'd4, 5'd0, 6'd0, 26'h100,   1'b1, 32'hB8100083, 32'h0);
      wait_drain();
      chk("addr_after_wrap", wr_addr, 32'd4);

      // base load in the same cycle as a write: word uses the old address
      step();
      wr_ready = 1'b0;
      send(5'd12, 5'd5, 5'd6, 5'd0, 6'd0, 26'h10, 1'b1, 32'hB88100C5, 32'd4);
      wr_ready = 1'b1;
      base_load = 1'b1;
      base_addr = 32'h100;
      step();
      base_load = 1'b0;
      wr_ready = 1'b0;
      @(negedge clk);
      chk("base_over_inc", wr_addr, 32'h100);
      chk("count_before_reset", 32'(word_count), 32'd15);

      // reset with words buffered
      step();
      send(5'd17, 5'd1, 5'd0, 5'd0, 6'd0, 26'd2, 1'b0, 32'h0, 32'h0);
      send(5'd19, 5'd0, 5'd0, 5'd0, 6'd0, 26'd5, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("buffered_valid", 32'(wr_valid), 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(wr_valid), 32'd0);
      @(negedge clk);
      chk("midrst_addr", wr_addr, 32'h0);
      chk("midrst_count", 32'(word_count), 32'd0);
      chk("midrst_data", wr_data, 32'h0);
      step();
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_valid", 32'(wr_valid), 32'd0);
      step();
      wr_ready = 1'b1;
      send(5'd18, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0, 1'b1, 32'hB5000000, 32'h0);
      wait_drain();
      chk("post_rst_count", 32'(word_count), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
